// File: rtl/pci_pkg.sv
// Shared PCI definitions: bus command codes, master-abort timeout and the
// initiator state encoding. Imported by the master, the slave and the benches.
package pci_pkg;

    // Bus commands driven on CBE during the address phase.
    localparam logic [3:0] RD_CMD     = 4'b0010;  // I/O read
    localparam logic [3:0] WR_CMD     = 4'b0011;  // I/O write
    localparam logic [3:0] MEM_RD_CMD = 4'b0110;
    localparam logic [3:0] MEM_WR_CMD = 4'b0111;

    // Data-state cycles without DEVSEL before the initiator gives up.
    localparam int unsigned DEVSEL_TIMEOUT = 5;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StData,
        StAbort,
        StEnd
    } pci_state_e;

endpackage

// File: rtl/pci_master.sv
// PCI bus initiator. Runs single or burst I/O reads and writes requested on
// the user port and drives them onto the multiplexed AD bus.
//
// Ports
//   CLK, RST            clock, asynchronous active-low reset
//   start/rw/addr/len   request; sampled only while idle
//   wr_data/wr_valid    write word, held until wr_ready
//   wr_ready            combinational; high in a write transfer cycle
//   rd_data/rd_valid    registered read word with one-cycle strobe
//   busy/done/err       status; err is sticky until the next start
//   AD/CBE/FRAME/IRDY   bus outputs (AD tristated), FRAME/IRDY active-low
//   TRDY/DEVSEL         target responses, active-low
module pci_master
    import pci_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        start,
    input  logic        rw,
    input  logic [31:0] addr,
    input  logic [3:0]  len,
    input  logic [31:0] wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    output logic        busy,
    output logic        done,
    output logic        err,
    inout  wire  [31:0] AD,
    output logic [3:0]  CBE,
    output logic        FRAME,
    output logic        IRDY,
    input  logic        TRDY,
    input  logic        DEVSEL
);

    localparam logic [2:0] TimeoutCnt = 3'(DEVSEL_TIMEOUT);

    pci_state_e  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic        rw_q, rw_d;
    logic [3:0]  rem_q, rem_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        seen_q, seen_d;  // DEVSEL observed low in this transaction
    logic        frame_q, frame_d;
    logic        irdy_q, irdy_d;
    logic [3:0]  cbe_q, cbe_d;
    logic        oe_q, oe_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic        rd_valid_q, rd_valid_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        xfer;

    assign xfer = (state_q == StData) && !irdy_q && !TRDY;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rw_d       = rw_q;
        rem_d      = rem_q;
        cnt_d      = cnt_q;
        seen_d     = seen_q;
        frame_d    = frame_q;
        irdy_d     = irdy_q;
        cbe_d      = 4'b0000;
        oe_d       = oe_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        done_d     = 1'b0;
        err_d      = err_q;

        unique case (state_q)
            StIdle: begin
                frame_d = 1'b1;
                irdy_d  = 1'b1;
                oe_d    = 1'b0;
                if (start) begin
                    addr_d  = addr;
                    rw_d    = rw;
                    rem_d   = (len == 4'd0) ? 4'd1 : len;
                    cnt_d   = 3'd0;
                    seen_d  = 1'b0;
                    err_d   = 1'b0;
                    cbe_d   = rw ? RD_CMD : WR_CMD;
                    frame_d = 1'b0;
                    oe_d    = 1'b1;
                    state_d = StAddr;
                end
            end
            StAddr: begin
                state_d = StData;
                // A write word already offered during ADDR lets IRDY assert in the
                // first data cycle.
                irdy_d  = rw_q ? 1'b0 : !wr_valid;
                oe_d    = !rw_q;
                frame_d = !irdy_d && (rem_q == 4'd1);
            end
            StData: begin
                if (DEVSEL && !seen_q) begin
                    cnt_d = cnt_q + 3'd1;
                end
                seen_d = seen_q || !DEVSEL;
                if (xfer) begin
                    rem_d = rem_q - 4'd1;
                    if (rw_q) begin
                        rd_data_d  = AD;
                        rd_valid_d = 1'b1;
                    end
                    if (rem_q == 4'd1) begin
                        state_d = StEnd;
                        frame_d = 1'b1;
                        irdy_d  = 1'b1;
                        oe_d    = 1'b0;
                        done_d  = 1'b1;
                    end else if (rw_q) begin
                        irdy_d  = 1'b0;
                        frame_d = (rem_q == 4'd2);
                    end else begin
                        // Next write word must be offered before IRDY reasserts.
                        irdy_d  = 1'b1;
                        frame_d = 1'b0;
                    end
                end else if (cnt_d == TimeoutCnt) begin
                    state_d = StAbort;
                    frame_d = 1'b1;
                    irdy_d  = 1'b0;
                    oe_d    = 1'b0;
                end else if (irdy_q) begin
                    irdy_d  = !wr_valid;
                    frame_d = !irdy_d && (rem_q == 4'd1);
                end
            end
            StAbort: begin
                state_d = StEnd;
                frame_d = 1'b1;
                irdy_d  = 1'b1;
                oe_d    = 1'b0;
                err_d   = 1'b1;
                done_d  = 1'b1;
            end
            StEnd: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                frame_d = 1'b1;
                irdy_d  = 1'b1;
                oe_d    = 1'b0;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= StIdle;
            addr_q     <= 32'd0;
            rw_q       <= 1'b0;
            rem_q      <= 4'd0;
            cnt_q      <= 3'd0;
            seen_q     <= 1'b0;
            frame_q    <= 1'b1;
            irdy_q     <= 1'b1;
            cbe_q      <= 4'b0000;
            oe_q       <= 1'b0;
            rd_data_q  <= 32'd0;
            rd_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rw_q       <= rw_d;
            rem_q      <= rem_d;
            cnt_q      <= cnt_d;
            seen_q     <= seen_d;
            frame_q    <= frame_d;
            irdy_q     <= irdy_d;
            cbe_q      <= cbe_d;
            oe_q       <= oe_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // Address in ADDR, otherwise the user's write word passes straight through.
    assign AD = oe_q ? ((state_q == StAddr) ? addr_q : wr_data) : {32{1'bz}};

    assign wr_ready = xfer && !rw_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign CBE      = cbe_q;
    assign FRAME    = frame_q;
    assign IRDY     = irdy_q;

endmodule
